// File: rtl/sync_frame_pkg.sv
// Shared types and constants for the round-robin serial frame scheduler.
package sync_frame_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_PAY  = 3'd2,
    ST_PAR  = 3'd3,
    ST_GAP  = 3'd4
  } state_e;

  localparam logic [7:0] SYNC_DEFAULT = 8'hE8;
  localparam int         HDR_LEN      = 8;

  // Bits needed for a counter running 0 .. max_count-1.
  function automatic int cnt_width(input int max_count);
    if (max_count < 2) begin
      return 1;
    end else begin
      return $clog2(max_count);
    end
  endfunction

endpackage

// File: rtl/sync_frame_sched_if.sv
// Request/payload bus and serial output bundle of the frame scheduler.
interface sync_frame_sched_if #(
  parameter int NREQ = 4,
  parameter int PLEN = 8
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]      REQ;
  logic [NREQ*PLEN-1:0] DATA;
  logic [NREQ-1:0]      ACK;
  logic [IW-1:0]        GNT_ID;
  logic                 DOUT;
  logic                 DVALID;
  logic                 FSTART;
  logic                 BUSY;

  modport master (
    output REQ, DATA,
    input  ACK, GNT_ID, DOUT, DVALID, FSTART, BUSY
  );

  modport slave (
    input  REQ, DATA,
    output ACK, GNT_ID, DOUT, DVALID, FSTART, BUSY
  );
endinterface

// File: rtl/sync_frame_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or after the pointer wins.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IW-1:0]   idx_o,
  output logic            any_o
);

  logic [IW-1:0] cand_s [NREQ];
  logic          found_s;
  logic [IW-1:0] idx_s;

  // Search order: pointer, pointer+1, ... wrapping at NREQ-1.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      cand_s[i] = IW'((int'(ptr_i) + i) % NREQ);
    end
  end

  // Pick the first requesting candidate in search order.
  always_comb begin
    found_s = 1'b0;
    idx_s   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found_s && req_i[cand_s[i]]) begin
        found_s = 1'b1;
        idx_s   = cand_s[i];
      end else begin
        idx_s   = idx_s;
      end
    end
  end

  // One-hot form of the winning index.
  always_comb begin
    gnt_o = '0;
    if (found_s) begin
      gnt_o[idx_s] = 1'b1;
    end else begin
      gnt_o = '0;
    end
  end

  assign idx_o = idx_s;
  assign any_o = found_s;

endmodule

// File: rtl/sync_frame_sched.sv
// Round-robin scheduler emitting header + payload (+ optional parity) frames on one serial line.
// Optional even-parity bit after the payload: define SYNC_FRAME_PARITY_EN.
module sync_frame_sched
  import sync_frame_pkg::*;
#(
  parameter int         NREQ = 4,
  parameter int         PLEN = 8,
  parameter logic [7:0] SYNC = SYNC_DEFAULT,
  parameter int         GAP  = 2
) (
  input logic               CLK,
  input logic               RST,
  sync_frame_sched_if.slave bus
);

  localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int M1   = (PLEN > HDR_LEN) ? PLEN : HDR_LEN;
  localparam int CMAX = (GAP > M1) ? GAP : M1;
  localparam int CW   = cnt_width(CMAX);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   gnt_id_q, gnt_id_d;
  logic [PLEN-1:0] shreg_q, shreg_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic            dout_q, dout_d;
  logic            dvalid_q, dvalid_d;
  logic            fstart_q, fstart_d;
  logic            busy_q, busy_d;

  logic [NREQ-1:0] arb_gnt_s;
  logic [IW-1:0]   arb_idx_s;
  logic            arb_any_s;
  logic [PLEN-1:0] win_data_s;
  logic [2:0]      hdr_idx_s;

`ifdef SYNC_FRAME_PARITY_EN
  logic par_q, par_d;

  function automatic logic even_par(input logic [PLEN-1:0] v);
    return ^v;
  endfunction
`endif

  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
    .req_i (bus.REQ),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt_s),
    .idx_o (arb_idx_s),
    .any_o (arb_any_s)
  );

  // Payload of the arbitration winner.
  always_comb begin
    win_data_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      win_data_s = win_data_s | ({PLEN{arb_gnt_s[i]}} & bus.DATA[i*PLEN +: PLEN]);
    end
  end

  // Output registers present the bit of the cycle being entered, hence the look-ahead index.
  assign hdr_idx_s = 3'd6 - cnt_q[2:0];

  // Next-state, arbitration and registered-output look-ahead.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ptr_d    = ptr_q;
    gnt_id_d = gnt_id_q;
    shreg_d  = shreg_q;
    ack_d    = '0;
    dout_d   = 1'b0;
    fstart_d = 1'b0;
`ifdef SYNC_FRAME_PARITY_EN
    par_d    = par_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (arb_any_s) begin
          state_d  = ST_HDR;
          cnt_d    = '0;
          ptr_d    = (arb_idx_s == IW'(NREQ - 1)) ? '0 : arb_idx_s + IW'(1);
          gnt_id_d = arb_idx_s;
          shreg_d  = win_data_s;
          ack_d    = arb_gnt_s;
          dout_d   = SYNC[7];
          fstart_d = 1'b1;
`ifdef SYNC_FRAME_PARITY_EN
          par_d    = even_par(win_data_s);
`endif
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_HDR: begin
        if (cnt_q == CW'(HDR_LEN - 1)) begin
          state_d = ST_PAY;
          cnt_d   = '0;
          dout_d  = shreg_q[PLEN-1];
          shreg_d = shreg_q << 1;
        end else begin
          cnt_d   = cnt_q + CW'(1);
          dout_d  = SYNC[hdr_idx_s];
        end
      end
      ST_PAY: begin
        if (cnt_q == CW'(PLEN - 1)) begin
          cnt_d   = '0;
`ifdef SYNC_FRAME_PARITY_EN
          state_d = ST_PAR;
          dout_d  = par_q;
`else
          state_d = ST_GAP;
`endif
        end else begin
          cnt_d   = cnt_q + CW'(1);
          dout_d  = shreg_q[PLEN-1];
          shreg_d = shreg_q << 1;
        end
      end
      ST_PAR: begin
        state_d = ST_GAP;
        cnt_d   = '0;
      end
      ST_GAP: begin
        if (cnt_q == CW'(GAP - 1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
    dvalid_d = (state_d == ST_HDR) || (state_d == ST_PAY) || (state_d == ST_PAR);
    busy_d   = (state_d != ST_IDLE);
  end

  // State, pointer and output registers; reset truncates any frame in flight.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      ptr_q    <= '0;
      gnt_id_q <= '0;
      shreg_q  <= '0;
      ack_q    <= '0;
      dout_q   <= 1'b0;
      dvalid_q <= 1'b0;
      fstart_q <= 1'b0;
      busy_q   <= 1'b0;
`ifdef SYNC_FRAME_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ptr_q    <= ptr_d;
      gnt_id_q <= gnt_id_d;
      shreg_q  <= shreg_d;
      ack_q    <= ack_d;
      dout_q   <= dout_d;
      dvalid_q <= dvalid_d;
      fstart_q <= fstart_d;
      busy_q   <= busy_d;
`ifdef SYNC_FRAME_PARITY_EN
      par_q    <= par_d;
`endif
    end
  end

  assign bus.ACK    = ack_q;
  assign bus.GNT_ID = gnt_id_q;
  assign bus.DOUT   = dout_q;
  assign bus.DVALID = dvalid_q;
  assign bus.FSTART = fstart_q;
  assign bus.BUSY   = busy_q;

endmodule

// File: tb/tb_sync_frame_sched.sv
// Randomized bench for sync_frame_sched against a frame-level queue model; SYNC_FRAME_PARITY_EN selects the parity build.
module tb_sync_frame_sched;
  localparam int NREQ = 4;
  localparam int PLEN = 8;
  localparam int IW   = 2;
  localparam int GAPN = 2;
`ifdef SYNC_FRAME_PARITY_EN
  localparam int FLEN = 8 + PLEN + 1;
`else
  localparam int FLEN = 8 + PLEN;
`endif
  localparam int HN = 8192;

  typedef struct packed {
    logic [NREQ-1:0] ack;
    logic [IW-1:0]   gnt;
    logic            dout;
    logic            dvalid;
    logic            fstart;
    logic            busy;
  } rec_t;

  typedef struct {
    string       name;
    logic [31:0] act;
    logic [31:0] exp;
  } lchk_t;

  logic CLK = 1'b0;
  logic RST;
  logic chk_en = 1'b0;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  sync_frame_sched_if #(.NREQ(NREQ), .PLEN(PLEN)) bus ();

  sync_frame_sched #(.NREQ(NREQ), .PLEN(PLEN), .SYNC(8'hE8), .GAP(GAPN)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Frame-level model: a grant expands into its full per-cycle output sequence plus one idle cycle.
  rec_t        q[$];
  rec_t        exp_r;
  int          m_ptr;
  logic [IW-1:0] m_gnt;
  logic [7:0]  sync_v = 8'hE8;

  task automatic grant_frame(input logic [NREQ-1:0] req, input logic [NREQ*PLEN-1:0] data);
    int w;
    logic [PLEN-1:0] pl;
    rec_t r;
    w = -1;
    for (int off = 0; off < NREQ; off++) begin
      if (w < 0 && req[(m_ptr + off) % NREQ]) w = (m_ptr + off) % NREQ;
    end
    pl = data[w*PLEN +: PLEN];
    m_ptr <= (w + 1) % NREQ;
    m_gnt <= IW'(w);
    for (int k = 0; k < 8 + PLEN + GAPN + 1 + (FLEN - 8 - PLEN); k++) begin
      r = '0;
      r.gnt = IW'(w);
      if (k < 8) begin
        r.dout = sync_v[7-k];
        r.dvalid = 1'b1;
      end else if (k < 8 + PLEN) begin
        r.dout = pl[PLEN-1-(k-8)];
        r.dvalid = 1'b1;
      end else if (k < FLEN) begin
        r.dout = ^pl;
        r.dvalid = 1'b1;
      end
      r.busy = (k < FLEN + GAPN);
      if (k == 0) begin
        r.ack = NREQ'(1) << w;
        r.fstart = 1'b1;
      end
      q.push_back(r);
    end
  endtask

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      q.delete();
      m_ptr <= 0;
      m_gnt <= '0;
      exp_r <= '0;
    end else if (q.size() != 0) begin
      exp_r <= q.pop_front();
    end else if (bus.REQ != '0) begin
      grant_frame(bus.REQ, bus.DATA);
      exp_r <= q.pop_front();
    end else begin
      exp_r <= '{ack: '0, gnt: m_gnt, dout: 1'b0, dvalid: 1'b0, fstart: 1'b0, busy: 1'b0};
    end
  end

  logic            hist_dout   [HN];
  logic            hist_dvalid [HN];
  logic            hist_fstart [HN];
  logic [NREQ-1:0] hist_ack    [HN];
  logic [IW-1:0]   hist_gnt    [HN];
  lchk_t           lq[$];

  // Single compare process: model vs DUT every cycle, plus queued literal checks.
  always @(negedge CLK) begin
    lchk_t c;
    rec_t  act;
    if (cyc < HN) begin
      hist_dout[cyc]   = bus.DOUT;
      hist_dvalid[cyc] = bus.DVALID;
      hist_fstart[cyc] = bus.FSTART;
      hist_ack[cyc]    = bus.ACK;
      hist_gnt[cyc]    = bus.GNT_ID;
    end
    if (chk_en) begin
      act = '{ack: bus.ACK, gnt: bus.GNT_ID, dout: bus.DOUT, dvalid: bus.DVALID,
              fstart: bus.FSTART, busy: bus.BUSY};
      vectors++;
      if (act !== exp_r) begin
        miscompares++;
        $display("FAIL model cycle %0d: got ack=%b gnt=%0d dout=%b dv=%b fs=%b busy=%b, expected ack=%b gnt=%0d dout=%b dv=%b fs=%b busy=%b",
                 cyc, act.ack, act.gnt, act.dout, act.dvalid, act.fstart, act.busy,
                 exp_r.ack, exp_r.gnt, exp_r.dout, exp_r.dvalid, exp_r.fstart, exp_r.busy);
      end
    end
    while (lq.size() != 0) begin
      c = lq.pop_front();
      vectors++;
      if (c.act !== c.exp) begin
        miscompares++;
        $display("FAIL %s: got %0h expected %0h", c.name, c.act, c.exp);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    lq.push_back('{name: name, act: act, exp: exp});
  endtask

  task automatic do_reset();
    @(posedge CLK); #1 RST = 1'b1;
    @(posedge CLK); #1 RST = 1'b0;
  endtask

  task automatic rand_data();
    for (int i = 0; i < NREQ; i++) bus.DATA[i*PLEN +: PLEN] = PLEN'($urandom);
  endtask

  // Issue one request pulse while idle and let the frame complete; g is the first frame cycle.
  task automatic one_frame(input logic [NREQ-1:0] req, output int g);
    bus.REQ = req;
    g = cyc + 1;
    @(posedge CLK); #1 bus.REQ = '0;
    repeat (20) @(posedge CLK);
    #1;
  endtask

  initial begin
    int g, g2, cnt, pos, n;
    logic [15:0] exp1;
    logic [7:0]  win, hdr;
    RST = 1'b1;
    bus.REQ = '0;
    bus.DATA = '0;
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
    chk_en = 1'b1;
    check("reset_outputs", {22'd0, bus.ACK, bus.GNT_ID, bus.DOUT, bus.DVALID, bus.FSTART, bus.BUSY}, 32'd0);

    // Single request, payload A5.
    rand_data();
    bus.DATA[0 +: PLEN] = 8'hA5;
    one_frame(4'b0001, g);
    exp1 = 16'b1110_1000_1010_0101;
    for (int k = 0; k < 16; k++) check($sformatf("a5_bit%0d", k), {31'd0, hist_dout[g+k]}, {31'd0, exp1[15-k]});
    check("a5_ack", {28'd0, hist_ack[g]}, 32'h1);
    check("a5_ack_width", {28'd0, hist_ack[g+1]}, 32'h0);
    check("a5_fstart", {30'd0, hist_fstart[g], hist_fstart[g+1]}, 32'h2);
    check("a5_gap", {29'd0, hist_dout[g+16], hist_dout[g+17], hist_dvalid[g+16]}, 32'h0);
    cnt = 0;
    pos = -1;
    for (int j = g; j < g + 18; j++) begin
      for (int b = 0; b < 8; b++) win[7-b] = hist_dout[j-7+b];
      if (win == 8'hE8) begin
        cnt++;
        pos = j;
      end
    end
    check("a5_hdr_hits", cnt, 32'd1);
    check("a5_hdr_pos", pos - g, 32'd7);

    // All requesters held: rotation 0,1,2,3,0 every 19 cycles.
    do_reset();
    rand_data();
    bus.REQ = 4'hF;
    g = cyc + 1;
    repeat (5 * 19 + 2) @(posedge CLK);
    #1 bus.REQ = '0;
    repeat (25) @(posedge CLK);
    #1;
    for (int k = 0; k < 5; k++) begin
      n = k % 4;
      check($sformatf("rr_fstart%0d", k), {31'd0, hist_fstart[g+19*k]}, 32'd1);
      check($sformatf("rr_gnt%0d", k), {30'd0, hist_gnt[g+19*k]}, n);
      check($sformatf("rr_ack%0d", k), {28'd0, hist_ack[g+19*k]}, 32'd1 << n);
      check($sformatf("rr_ackw%0d", k), {28'd0, hist_ack[g+19*k+1]}, 32'd0);
    end

    // Pointer at 2 with requesters 0 and 1 pending: wrap to 0, then pointer is 1.
    do_reset();
    rand_data();
    one_frame(4'b0001, g);
    one_frame(4'b0010, g);
    one_frame(4'b0011, g);
    check("wrap_gnt", {30'd0, hist_gnt[g]}, 32'd0);
    one_frame(4'b0011, g);
    check("wrap_next_gnt", {30'd0, hist_gnt[g]}, 32'd1);

    // Reset during payload cycle 3, then a fresh grant to requester 2.
    do_reset();
    rand_data();
    bus.REQ = 4'b0001;
    g = cyc + 1;
    @(posedge CLK); #1 bus.REQ = '0;
    repeat (11) @(posedge CLK);
    #3 RST = 1'b1;
    #1;
    check("rst_mid_frame", {29'd0, bus.DOUT, bus.DVALID, bus.BUSY}, 32'd0);
    @(posedge CLK); #1 RST = 1'b0;
    one_frame(4'b0100, g2);
    check("rst_regrant_gnt", {30'd0, hist_gnt[g2]}, 32'd2);
    check("rst_regrant_fs", {31'd0, hist_fstart[g2]}, 32'd1);
    for (int b = 0; b < 8; b++) hdr[7-b] = hist_dout[g2+b];
    check("rst_regrant_hdr", {24'd0, hdr}, 32'hE8);

    // Short request pulse from requester 1 mid-frame is ignored.
    do_reset();
    rand_data();
    bus.REQ = 4'b0001;
    g = cyc + 1;
    @(posedge CLK); #1 bus.REQ = '0;
    repeat (3) @(posedge CLK);
    #1 bus.REQ = 4'b0010;
    @(posedge CLK); #1 bus.REQ = '0;
    repeat (22) @(posedge CLK);
    #1;
    cnt = 0;
    for (int j = g; j < g + 25; j++) if (hist_ack[j][1]) cnt++;
    check("pulse_no_ack1", cnt, 32'd0);

    // Payload 07: frame length and final bit.
    do_reset();
    rand_data();
    bus.DATA[0 +: PLEN] = 8'h07;
    one_frame(4'b0001, g);
    cnt = 0;
    for (int j = g; j < g + 30; j++) begin
      if (hist_dvalid[j] && (j == g + cnt)) cnt++;
    end
    check("p07_dvalid_len", cnt, FLEN);
    check("p07_last_bit", {31'd0, hist_dout[g+FLEN-1]}, 32'd1);
    check("p07_after", {30'd0, hist_dout[g+FLEN], hist_dvalid[g+FLEN]}, 32'd0);

    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      @(posedge CLK);
      #1;
      bus.REQ = NREQ'($urandom) & NREQ'($urandom);
      rand_data();
      RST = ($urandom_range(0, 399) == 0);
    end
    @(posedge CLK); #1 RST = 1'b0;
    repeat (25) @(posedge CLK);
    @(negedge CLK);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
